// File: rtl/multicycle_main_control_if.sv
// multicycle_main_control_if: opcode/handshake inputs and datapath control outputs of the multicycle MIPS controller
interface multicycle_main_control_if;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       ALUOp1;
    logic       ALUOp0;
    logic       IllegalOp;
    logic [3:0] State;
    modport master (
        input  Opcode, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp1, ALUOp0, IllegalOp, State
    );
    modport slave (
        output Opcode, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp1, ALUOp0, IllegalOp, State
    );
endinterface

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: FSM sequencing the multicycle MIPS datapath with memory-ready stalls
module multicycle_main_control #(
    parameter bit WAIT_EN = 1'b1
) (
    input logic clk,
    input logic reset_n,
    multicycle_main_control_if.master bus
);
    localparam logic [3:0] RST = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMRD = 4'd4,
                           MEMWB = 4'd5, MEMWR = 4'd6, EXEC = 4'd7, RWB = 4'd8, BRANCH = 4'd9, JUMP = 4'd10;
    logic [3:0] state, state_nxt;
    logic       rdy, legal, fetch_go;
    assign rdy = WAIT_EN ? bus.MemReady : 1'b1;
    assign legal = bus.Opcode inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= RST;
        else state <= state_nxt;
    always_comb begin
        state_nxt = RST;
        case (state)
            RST:    state_nxt = FETCH;
            FETCH:  state_nxt = rdy ? DECODE : FETCH;
            DECODE: state_nxt = (bus.Opcode == 6'b000000) ? EXEC :
                                (bus.Opcode == 6'b100011 || bus.Opcode == 6'b101011) ? MEMADR :
                                (bus.Opcode == 6'b000100) ? BRANCH :
                                (bus.Opcode == 6'b000010) ? JUMP : FETCH;
            MEMADR: state_nxt = (bus.Opcode == 6'b100011) ? MEMRD : MEMWR;
            MEMRD:  state_nxt = rdy ? MEMWB : MEMRD;
            MEMWR:  state_nxt = rdy ? FETCH : MEMWR;
            EXEC:   state_nxt = RWB;
            MEMWB, RWB, BRANCH, JUMP: state_nxt = FETCH;
            default: state_nxt = RST;
        endcase
    end
    // IRWrite/PCWrite in FETCH are the only outputs that look at MemReady
    assign fetch_go        = (state == FETCH) && rdy;
    assign bus.PCWrite     = fetch_go || (state == JUMP);
    assign bus.IRWrite     = fetch_go;
    assign bus.PCWriteCond = state == BRANCH;
    assign bus.IorD        = (state == MEMRD) || (state == MEMWR);
    assign bus.MemRead     = (state == FETCH) || (state == MEMRD);
    assign bus.MemWrite    = state == MEMWR;
    assign bus.MemtoReg    = state == MEMWB;
    assign bus.RegDst      = state == RWB;
    assign bus.RegWrite    = (state == MEMWB) || (state == RWB);
    assign bus.ALUSrcA     = (state == MEMADR) || (state == EXEC) || (state == BRANCH);
    assign bus.ALUSrcB     = (state == FETCH) ? 2'b01 : (state == DECODE) ? 2'b11 :
                             (state == MEMADR) ? 2'b10 : 2'b00;
    assign bus.PCSource    = (state == BRANCH) ? 2'b01 : (state == JUMP) ? 2'b10 : 2'b00;
    assign bus.ALUOp1      = state == EXEC;
    assign bus.ALUOp0      = state == BRANCH;
    assign bus.IllegalOp   = (state == DECODE) && !legal;
    assign bus.State       = state;
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: path-queue reference model with per-cycle output compare, plus directed latency and reset checks
module tb_multicycle_main_control;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_state = 0;
    int   path[$];
    multicycle_main_control_if bus();
    multicycle_main_control dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite | MemtoReg,RegDst,RegWrite,ALUSrcA | ALUSrcB | PCSource | ALUOp1,ALUOp0 | IllegalOp}
    function automatic logic [16:0] exp_out(int s, logic rdy, logic [5:0] op);
        logic ill;
        ill = !(op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd2});
        case (s)
            1:  return {rdy, 4'b0010, rdy, 4'b0000, 2'b01, 2'b00, 2'b00, 1'b0};
            2:  return {6'b000000, 4'b0000, 2'b11, 2'b00, 2'b00, ill};
            3:  return {6'b000000, 4'b0001, 2'b10, 2'b00, 2'b00, 1'b0};
            4:  return {6'b001100, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0};
            5:  return {6'b000000, 4'b1010, 2'b00, 2'b00, 2'b00, 1'b0};
            6:  return {6'b001010, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0};
            7:  return {6'b000000, 4'b0001, 2'b00, 2'b00, 2'b10, 1'b0};
            8:  return {6'b000000, 4'b0110, 2'b00, 2'b00, 2'b00, 1'b0};
            9:  return {6'b010000, 4'b0001, 2'b00, 2'b01, 2'b01, 1'b0};
            10: return {6'b100000, 4'b0000, 2'b00, 2'b10, 2'b00, 1'b0};
            default: return 17'd0;
        endcase
    endfunction
    function automatic logic [16:0] dut_out();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource,
                bus.ALUOp1, bus.ALUOp0, bus.IllegalOp};
    endfunction
    // each instruction is the list of states it visits after FETCH; waiting states hold while not ready
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0;
            path.delete();
        end else if (m_state == 0) m_state = 1;
        else if ((m_state == 1 || m_state == 4 || m_state == 6) && !bus.MemReady) m_state = m_state;
        else if (m_state == 1) begin
            case (bus.Opcode)
                6'd0:    path = '{2, 7, 8};
                6'd35:   path = '{2, 3, 4, 5};
                6'd43:   path = '{2, 3, 6};
                6'd4:    path = '{2, 9};
                6'd2:    path = '{2, 10};
                default: path = '{2};
            endcase
            m_state = path.pop_front();
        end else if (path.size() == 0) m_state = 1;
        else m_state = path.pop_front();
    end
    always @(negedge clk) begin
        n_checks++;
        if (int'(bus.State) != m_state) begin
            n_fail++;
            $display("FAIL state: got %0d expected %0d at %0t", bus.State, m_state, $time);
        end
        n_checks++;
        if (dut_out() !== exp_out(m_state, bus.MemReady, bus.Opcode)) begin
            n_fail++;
            $display("FAIL outputs(state %0d): got %b expected %b at %0t", m_state, dut_out(),
                     exp_out(m_state, bus.MemReady, bus.Opcode), $time);
        end
    end
    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask
    // called at the negedge of a FETCH first cycle; returns at the next FETCH first cycle
    task automatic run_instr(input string name, input logic [5:0] op, input int fw, input int mw, input int exp_cyc);
        int  cyc;
        bit  left;
        left = 1'b0;
        bus.Opcode = op;
        for (cyc = 1; cyc <= 60; cyc++) begin
            #2;
            if (bus.State == 4'd1 && fw > 0) begin
                bus.MemReady = 1'b0;
                fw--;
            end else if ((bus.State == 4'd4 || bus.State == 4'd6) && mw > 0) begin
                bus.MemReady = 1'b0;
                mw--;
            end else bus.MemReady = 1'b1;
            @(negedge clk);
            if (bus.State != 4'd1) left = 1'b1;
            else if (left) break;
        end
        check(name, cyc, exp_cyc);
    endtask
    initial begin
        bus.Opcode = 6'd0;
        bus.MemReady = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", int'(bus.State), 0);
        check("reset_outputs", int'(dut_out()), 0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("first_fetch", int'(bus.State), 1);
        run_instr("lat_rtype", 6'b000000, 0, 0, 4);
        run_instr("lat_lw_wait3", 6'b100011, 0, 3, 8);
        run_instr("lat_beq", 6'b000100, 0, 0, 3);
        run_instr("lat_illegal", 6'b111111, 0, 0, 2);
        run_instr("lat_rtype_fetchwait2", 6'b000000, 2, 0, 6);
        run_instr("lat_sw", 6'b101011, 0, 0, 4);
        run_instr("lat_j", 6'b000010, 0, 0, 3);
        run_instr("lat_lw", 6'b100011, 0, 0, 5);
        run_instr("lat_sw_wait2", 6'b101011, 0, 2, 6);
        bus.Opcode = 6'b101011;
        for (int i = 0; i < 20 && bus.State != 4'd6; i++) begin
            #2 bus.MemReady = 1'b1;
            @(negedge clk);
        end
        #2 bus.MemReady = 1'b0;
        @(negedge clk);
        check("memwr_held", int'(bus.State), 6);
        check("memwr_strobe", int'(bus.MemWrite), 1);
        #3 reset_n = 1'b0;
        #1;
        check("async_reset_state", int'(bus.State), 0);
        check("async_reset_outputs", int'(dut_out()), 0);
        @(negedge clk);
        #2 begin
            reset_n = 1'b1;
            bus.MemReady = 1'b1;
        end
        @(negedge clk);
        check("resume_fetch", int'(bus.State), 1);
        run_instr("lat_rtype_after_reset", 6'b000000, 0, 0, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
